rng_health_monitor: RTL and testbench
=====================================

# rng_health_monitor

Parametrised online health monitor for the ALFSR random-bit stream, successor to the fixed four-test NIST SP 800-22 checker. It consumes one qualified bit per cycle and runs four windowed tests (monobit, block frequency, runs, longest run) with configurable window, block size and tolerances. It reports per-window statistics and sticky error flags. It sits between the digitised RNG output and the status pins/registers of the top level.

## Interface
- WIN_LOG2, 10: log2 of window length N (N = 1024).
- BLK_LOG2, 5: log2 of block length M (M = 32); must satisfy 1 ≤ BLK_LOG2 ≤ WIN_LOG2.
- MONO_TOL, 64: monobit fails when |ones − N/2| > MONO_TOL.
- BLK_TOL, 8: block test fails when any block has |blk_ones − M/2| > BLK_TOL.
- RUNS_TOL, 64: runs test fails when |runs − N/2| > RUNS_TOL.
- MAX_RUN, 20: longest-run test fails when any run of identical bits is longer than MAX_RUN.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rnd_in  in  1  random bit.
- rnd_valid  in  1  rnd_in is accepted on a rising edge only while this is high.
- clear  in  1  synchronous clear of the sticky error flags only.
- win_done  out  1  one-cycle pulse: window results updated.
- ones_count  out  WIN_LOG2+1  number of ones in the last completed window.
- runs_count  out  WIN_LOG2+1  number of runs in the last completed window.
- win_cnt  out  16  completed windows since reset, saturating at 0xFFFF.
- err_mono, err_block, err_runs, err_longrun  out  1 each  sticky test failures.
- err_any  out  1  OR of the four sticky flags (combinational).

## Operation
- Internal state: bit index idx (WIN_LOG2 bits), ones accumulator, block-ones accumulator (BLK_LOG2+1 bits), runs accumulator, previous bit, current run length, maximum run length, and a block-fail pending bit. Run-length counters saturate at N.
- Accepted bit at idx = 0: ones = rnd_in, runs = 1, cur_run = 1, max_run = 1, block pending = 0.
- Accepted bit at idx > 0: ones += rnd_in. If rnd_in ≠ prev, runs += 1 and cur_run = 1; otherwise cur_run += 1. max_run = max(max_run, new cur_run).
- Block end, when idx[BLK_LOG2−1:0] = M−1: blk_ones includes the current bit. If |blk_ones − M/2| > BLK_TOL, set block pending. Then zero blk_ones.
- Window end, when idx = N−1 is accepted:
  - Load ones_count and runs_count with their final values, including the current bit.
  - OR each test result into its sticky flag.
  - Increment win_cnt.
  - Wrap idx to 0. The next accepted bit starts a fresh window, and runs do not carry across the window boundary.
- Comparisons use unsigned magnitudes computed at WIN_LOG2+2 bits, so no wrap occurs.
- clear zeroes all four sticky flags. If clear coincides with a window end, the new results win: a flag whose test failed in that window is 1 afterwards.
- rnd_valid low: no state changes except clear.

## Timing
- Reset (rst_n low at a rising edge): all outputs are 0, all counters are 0, and any partial window is discarded.
- Latency: the edge that accepts bit N−1 updates ones_count, runs_count, win_cnt and the flags. win_done is high for exactly the following cycle.
- Back-to-back operation: a bit accepted in the cycle where win_done is high is bit 0 of the next window, with no dead cycle.
- Outputs hold their values between windows.
- With continuous valid input, a window completes every N cycles.

## Test plan
All values below use default parameters.
- **All zeros:** 1024 valid zeros → win_done one cycle after the 1024th bit; ones_count = 0, runs_count = 1; all four flags = 1; err_any = 1; win_cnt = 1.
- **Alternating 0101…:** 1024 bits → ones_count = 512, runs_count = 1024; err_runs = 1; err_mono = err_block = err_longrun = 0.
- **Clean pattern 0011 repeated:** 1024 bits → ones_count = 512, runs_count = 512; all flags 0. Run a second back-to-back window started in the win_done cycle → identical results, win_cnt = 2.
- **Gapped valid:** same 0011 stream with rnd_valid randomly deasserted and rnd_in toggled while invalid → results identical to the clean-pattern test; win_done occurs only after 1024 accepted bits.
- **Sticky and clear:** all-zeros window, then a 0011 window → flags remain 1. Pulse clear → all flags 0. Assert clear in the same cycle as the last bit of an all-zeros window → flags 1 after the edge.
- **Reset mid-window:** reset after 500 bits → all outputs 0. A following full 0011 window → ones_count = 512, runs_count = 512, win_cnt = 1.

Source files
------------

// File: rtl/rng_health_monitor.sv
// Online health monitor for a random-bit stream: windowed monobit, block
// frequency, runs and longest-run tests with per-window stats and sticky flags.
module rng_health_monitor #(
    parameter int WIN_LOG2 = 10,
    parameter int BLK_LOG2 = 5,
    parameter int MONO_TOL = 64,
    parameter int BLK_TOL  = 8,
    parameter int RUNS_TOL = 64,
    parameter int MAX_RUN  = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rnd_in,
    input  logic                rnd_valid,
    input  logic                clear,
    output logic                win_done,
    output logic [WIN_LOG2:0]   ones_count,
    output logic [WIN_LOG2:0]   runs_count,
    output logic [15:0]         win_cnt,
    output logic                err_mono,
    output logic                err_block,
    output logic                err_runs,
    output logic                err_longrun,
    output logic                err_any
);

    localparam int IW = WIN_LOG2;
    localparam int CW = WIN_LOG2 + 1;
    localparam int MW = WIN_LOG2 + 2;
    localparam int BW = BLK_LOG2 + 1;

    localparam logic [CW-1:0] N_VAL      = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [MW-1:0] HALF_N     = MW'(2 ** (WIN_LOG2 - 1));
    localparam logic [MW-1:0] HALF_M     = MW'(2 ** (BLK_LOG2 - 1));
    localparam logic [MW-1:0] MONO_TOL_W = MW'(MONO_TOL);
    localparam logic [MW-1:0] BLK_TOL_W  = MW'(BLK_TOL);
    localparam logic [MW-1:0] RUNS_TOL_W = MW'(RUNS_TOL);
    localparam logic [MW-1:0] MAX_RUN_W  = MW'(MAX_RUN);

    logic [IW-1:0] idx;
    logic [CW-1:0] ones_acc;
    logic [CW-1:0] runs_acc;
    logic [CW-1:0] cur_run;
    logic [CW-1:0] max_run;
    logic [BW-1:0] blk_ones;
    logic          prev_bit;
    logic          blk_pend;

    logic          win_start;
    logic          win_end;
    logic          blk_end;
    logic          win_fire;
    logic [CW-1:0] ones_nx;
    logic [CW-1:0] runs_nx;
    logic [CW-1:0] cur_nx;
    logic [CW-1:0] max_nx;
    logic [BW-1:0] blk_nx;
    logic          blk_fail;
    logic          pend_nx;
    logic          mono_fail;
    logic          runs_fail;
    logic          long_fail;
    logic          err_mono_nx;
    logic          err_block_nx;
    logic          err_runs_nx;
    logic          err_longrun_nx;

    function automatic logic [MW-1:0] abs_diff(input logic [MW-1:0] a,
                                               input logic [MW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Next-window values include the bit being accepted this cycle, so the
    // window-end results can be latched on the same edge as the last bit.
    always_comb begin
        win_start = (idx == '0);
        win_end   = &idx;
        blk_end   = &idx[BLK_LOG2-1:0];
        win_fire  = rnd_valid & win_end;

        if (win_start) begin
            ones_nx = CW'(rnd_in);
            runs_nx = CW'(1);
            cur_nx  = CW'(1);
            max_nx  = CW'(1);
        end else begin
            ones_nx = ones_acc + CW'(rnd_in);
            if (rnd_in != prev_bit) begin
                runs_nx = runs_acc + CW'(1);
                cur_nx  = CW'(1);
            end else begin
                runs_nx = runs_acc;
                cur_nx  = (cur_run == N_VAL) ? N_VAL : cur_run + CW'(1);
            end
            max_nx = (cur_nx > max_run) ? cur_nx : max_run;
        end

        blk_nx    = blk_ones + BW'(rnd_in);
        blk_fail  = blk_end && (abs_diff(MW'(blk_nx), HALF_M) > BLK_TOL_W);
        pend_nx   = (win_start ? 1'b0 : blk_pend) | blk_fail;

        mono_fail = abs_diff(MW'(ones_nx), HALF_N) > MONO_TOL_W;
        runs_fail = abs_diff(MW'(runs_nx), HALF_N) > RUNS_TOL_W;
        long_fail = MW'(max_nx) > MAX_RUN_W;

        // A window result in the same cycle as clear takes priority over it.
        err_mono_nx    = (err_mono    & ~clear) | (win_fire & mono_fail);
        err_block_nx   = (err_block   & ~clear) | (win_fire & pend_nx);
        err_runs_nx    = (err_runs    & ~clear) | (win_fire & runs_fail);
        err_longrun_nx = (err_longrun & ~clear) | (win_fire & long_fail);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx         <= '0;
            ones_acc    <= '0;
            runs_acc    <= '0;
            cur_run     <= '0;
            max_run     <= '0;
            blk_ones    <= '0;
            prev_bit    <= 1'b0;
            blk_pend    <= 1'b0;
            win_done    <= 1'b0;
            ones_count  <= '0;
            runs_count  <= '0;
            win_cnt     <= '0;
            err_mono    <= 1'b0;
            err_block   <= 1'b0;
            err_runs    <= 1'b0;
            err_longrun <= 1'b0;
        end else begin
            win_done    <= win_fire;
            err_mono    <= err_mono_nx;
            err_block   <= err_block_nx;
            err_runs    <= err_runs_nx;
            err_longrun <= err_longrun_nx;
            if (rnd_valid) begin
                idx      <= idx + IW'(1);
                ones_acc <= ones_nx;
                runs_acc <= runs_nx;
                cur_run  <= cur_nx;
                max_run  <= max_nx;
                prev_bit <= rnd_in;
                blk_ones <= blk_end ? '0 : blk_nx;
                blk_pend <= pend_nx;
                if (win_end) begin
                    ones_count <= ones_nx;
                    runs_count <= runs_nx;
                    if (win_cnt != '1) begin
                        win_cnt <= win_cnt + 16'd1;
                    end
                end
            end
        end
    end

    assign err_any = err_mono | err_block | err_runs | err_longrun;

endmodule

// File: tb/tb_rng_health_monitor.sv
// Self-checking bench for rng_health_monitor: directed and random windows
// compared against a whole-window statistical model.
module tb_rng_health_monitor;

    localparam int WIN_LOG2 = 10;
    localparam int BLK_LOG2 = 5;
    localparam int N        = 1 << WIN_LOG2;
    localparam int M        = 1 << BLK_LOG2;
    localparam int MONO_TOL = 64;
    localparam int BLK_TOL  = 8;
    localparam int RUNS_TOL = 64;
    localparam int MAX_RUN  = 20;

    typedef logic [42:0] vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rnd_in;
    logic              rnd_valid;
    logic              clear;
    logic              win_done;
    logic [WIN_LOG2:0] ones_count;
    logic [WIN_LOG2:0] runs_count;
    logic [15:0]       win_cnt;
    logic              err_mono;
    logic              err_block;
    logic              err_runs;
    logic              err_longrun;
    logic              err_any;

    always #5 clk = ~clk;

    rng_health_monitor #(
        .WIN_LOG2 (WIN_LOG2),
        .BLK_LOG2 (BLK_LOG2),
        .MONO_TOL (MONO_TOL),
        .BLK_TOL  (BLK_TOL),
        .RUNS_TOL (RUNS_TOL),
        .MAX_RUN  (MAX_RUN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rnd_in      (rnd_in),
        .rnd_valid   (rnd_valid),
        .clear       (clear),
        .win_done    (win_done),
        .ones_count  (ones_count),
        .runs_count  (runs_count),
        .win_cnt     (win_cnt),
        .err_mono    (err_mono),
        .err_block   (err_block),
        .err_runs    (err_runs),
        .err_longrun (err_longrun),
        .err_any     (err_any)
    );

    int n_checks = 0;
    int n_pass   = 0;

    bit wbits [N];
    int exp_ones;
    int exp_runs;
    int exp_cnt;
    bit exp_mono;
    bit exp_blk;
    bit exp_runsf;
    bit exp_long;
    int early_done;
    bit timed_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t dut_vec();
        return {ones_count, runs_count, win_cnt,
                err_mono, err_block, err_runs, err_longrun, err_any};
    endfunction

    function automatic vec_t exp_vec();
        return {11'(exp_ones), 11'(exp_runs), 16'(exp_cnt),
                exp_mono, exp_blk, exp_runsf, exp_long,
                exp_mono | exp_blk | exp_runsf | exp_long};
    endfunction

    function automatic string fmt(input vec_t v);
        return $sformatf("ones=%0d runs=%0d cnt=%0d flags(m,b,r,l,any)=%b",
                         v[42:32], v[31:21], v[20:5], v[4:0]);
    endfunction

    // kind: 0 zeros, 1 alternating 0101, 2 repeated 0011, 3 biased random,
    // 4 random run lengths (exercises the longest-run test)
    task automatic fill_window(input int kind, input int pct);
        int i = 0;
        bit b = 1'($urandom_range(1));
        while (i < N) begin
            case (kind)
                0: begin wbits[i] = 1'b0; i++; end
                1: begin wbits[i] = bit'(i % 2); i++; end
                2: begin wbits[i] = bit'((i % 4) >= 2); i++; end
                3: begin wbits[i] = bit'($urandom_range(99) < pct); i++; end
                default: begin
                    int len = int'($urandom_range(30, 1));
                    for (int k = 0; k < len && i < N; k++) begin
                        wbits[i] = b;
                        i++;
                    end
                    b = ~b;
                end
            endcase
        end
    endtask

    // Whole-window statistics straight from the test definitions.
    task automatic model_window(input bit clr);
        int ones = 0;
        int runs = 1;
        int cur = 0;
        int longest = 0;
        bit bfail = 1'b0;
        for (int i = 0; i < N; i++) begin
            ones += int'(wbits[i]);
            if (i > 0 && wbits[i] != wbits[i-1]) runs++;
            cur = (i > 0 && wbits[i] == wbits[i-1]) ? cur + 1 : 1;
            if (cur > longest) longest = cur;
        end
        for (int blk = 0; blk < N / M; blk++) begin
            int s = 0;
            for (int j = 0; j < M; j++) s += int'(wbits[blk*M + j]);
            if ((s > M/2 ? s - M/2 : M/2 - s) > BLK_TOL) bfail = 1'b1;
        end
        if (clr) begin
            exp_mono = 0; exp_blk = 0; exp_runsf = 0; exp_long = 0;
        end
        exp_ones  = ones;
        exp_runs  = runs;
        exp_mono  |= ((ones > N/2 ? ones - N/2 : N/2 - ones) > MONO_TOL);
        exp_blk   |= bfail;
        exp_runsf |= ((runs > N/2 ? runs - N/2 : N/2 - runs) > RUNS_TOL);
        exp_long  |= (longest > MAX_RUN);
        exp_cnt   = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
    endtask

    task automatic model_reset();
        exp_ones = 0; exp_runs = 0; exp_cnt = 0;
        exp_mono = 0; exp_blk = 0; exp_runsf = 0; exp_long = 0;
    endtask

    // Feeds wbits; returns #1 after the edge that accepts the last bit.
    task automatic feed_window(input int gap_pct, input bit clr_last);
        int acc = 0;
        int steps = 0;
        early_done = 0;
        timed_out  = 1'b0;
        while (acc < N) begin
            if (steps >= 20 * N) begin
                timed_out = 1'b1;
                break;
            end
            steps++;
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                rnd_valid = 1'b0;
                rnd_in    = 1'($urandom_range(1));
                clear     = 1'b0;
            end else begin
                rnd_valid = 1'b1;
                rnd_in    = wbits[acc];
                clear     = clr_last && (acc == N - 1);
                acc++;
            end
            tick();
            if (acc < N && win_done === 1'b1) early_done++;
        end
        rnd_valid = 1'b0;
        clear     = 1'b0;
        model_window(clr_last);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rnd_valid = 1'b0; rnd_in = 1'b0; clear = 1'b0;
        repeat (3) tick();
        model_reset();
        n_checks++;
        if ({win_done, dut_vec()} !== {1'b0, exp_vec()})
            $display("FAIL reset_state: got done=%b %s, required done=0 %s",
                     win_done, fmt(dut_vec()), fmt(exp_vec()));
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        fill_window(2, 0);
        for (int w = 0; w < 2; w++) begin
            feed_window(0, 1'b0);
            n_checks++;
            if (timed_out !== 1'b0 || early_done !== 0 || win_done !== 1'b1)
                $display("FAIL b2b_timing[%0d]: early=%0d timeout=%b done=%b, required 0 0 1",
                         w, early_done, timed_out, win_done);
            else n_pass++;
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL b2b_result[%0d]: got %s, required %s",
                         w, fmt(dut_vec()), fmt(exp_vec()));
            else n_pass++;
        end
        n_checks++;
        if ({ones_count, runs_count, win_cnt, err_any} !== {11'd512, 11'd512, 16'd2, 1'b0})
            $display("FAIL b2b_known: got ones=%0d runs=%0d cnt=%0d any=%b, required 512 512 2 0",
                     ones_count, runs_count, win_cnt, err_any);
        else n_pass++;
        tick();
        n_checks++;
        if (win_done !== 1'b0)
            $display("FAIL b2b_pulse_width: got done=%b, required 0", win_done);
        else n_pass++;
    endtask

    task automatic test_gapped();
        fill_window(2, 0);
        feed_window(35, 1'b0);
        n_checks++;
        if (timed_out !== 1'b0 || early_done !== 0 || win_done !== 1'b1)
            $display("FAIL gapped_timing: early=%0d timeout=%b done=%b, required 0 0 1",
                     early_done, timed_out, win_done);
        else n_pass++;
        n_checks++;
        if (dut_vec() !== exp_vec())
            $display("FAIL gapped_result: got %s, required %s", fmt(dut_vec()), fmt(exp_vec()));
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if ({win_done, dut_vec()} !== {1'b0, exp_vec()})
            $display("FAIL gapped_hold: got done=%b %s, required done=0 %s",
                     win_done, fmt(dut_vec()), fmt(exp_vec()));
        else n_pass++;
    endtask

    task automatic test_all_zeros();
        fill_window(0, 0);
        feed_window(0, 1'b0);
        n_checks++;
        if (timed_out !== 1'b0 || early_done !== 0 || win_done !== 1'b1)
            $display("FAIL zeros_timing: early=%0d timeout=%b done=%b, required 0 0 1",
                     early_done, timed_out, win_done);
        else n_pass++;
        n_checks++;
        if ({ones_count, runs_count, err_mono, err_block, err_runs, err_longrun, err_any}
                !== {11'd0, 11'd1, 5'b11111})
            $display("FAIL zeros_known: got ones=%0d runs=%0d flags=%b, required 0 1 11111",
                     ones_count, runs_count,
                     {err_mono, err_block, err_runs, err_longrun, err_any});
        else n_pass++;
        n_checks++;
        if (dut_vec() !== exp_vec())
            $display("FAIL zeros_result: got %s, required %s", fmt(dut_vec()), fmt(exp_vec()));
        else n_pass++;
    endtask

    task automatic test_alternating();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        fill_window(1, 0);
        feed_window(0, 1'b0);
        n_checks++;
        if ({win_done, ones_count, runs_count, err_mono, err_block, err_runs, err_longrun}
                !== {1'b1, 11'd512, 11'd1024, 4'b0010})
            $display("FAIL alt_known: got done=%b ones=%0d runs=%0d flags=%b, required 1 512 1024 0010",
                     win_done, ones_count, runs_count,
                     {err_mono, err_block, err_runs, err_longrun});
        else n_pass++;
        n_checks++;
        if (dut_vec() !== exp_vec())
            $display("FAIL alt_result: got %s, required %s", fmt(dut_vec()), fmt(exp_vec()));
        else n_pass++;
    endtask

    task automatic test_sticky_clear();
        fill_window(0, 0);
        feed_window(0, 1'b0);
        fill_window(2, 0);
        feed_window(0, 1'b0);
        n_checks++;
        if (dut_vec() !== exp_vec())
            $display("FAIL sticky_hold: got %s, required %s", fmt(dut_vec()), fmt(exp_vec()));
        else n_pass++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_mono = 0; exp_blk = 0; exp_runsf = 0; exp_long = 0;
        n_checks++;
        if (dut_vec() !== exp_vec())
            $display("FAIL clear_pulse: got %s, required %s", fmt(dut_vec()), fmt(exp_vec()));
        else n_pass++;
        fill_window(0, 0);
        feed_window(0, 1'b1);
        n_checks++;
        if (dut_vec() !== exp_vec())
            $display("FAIL clear_vs_fail: got %s, required %s", fmt(dut_vec()), fmt(exp_vec()));
        else n_pass++;
        fill_window(2, 0);
        feed_window(0, 1'b1);
        n_checks++;
        if (dut_vec() !== exp_vec())
            $display("FAIL clear_vs_pass: got %s, required %s", fmt(dut_vec()), fmt(exp_vec()));
        else n_pass++;
    endtask

    task automatic test_random();
        for (int w = 0; w < 6; w++) begin
            fill_window((w % 3 == 2) ? 4 : 3, (w == 1) ? 43 : 50);
            feed_window(20, 1'b0);
            n_checks++;
            if (timed_out !== 1'b0 || early_done !== 0 || win_done !== 1'b1)
                $display("FAIL rand_timing[%0d]: early=%0d timeout=%b done=%b, required 0 0 1",
                         w, early_done, timed_out, win_done);
            else n_pass++;
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL rand_result[%0d]: got %s, required %s",
                         w, fmt(dut_vec()), fmt(exp_vec()));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_window();
        fill_window(2, 0);
        for (int i = 0; i < 500; i++) begin
            rnd_valid = 1'b1;
            rnd_in    = wbits[i];
            tick();
        end
        rnd_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        n_checks++;
        if ({win_done, dut_vec()} !== {1'b0, exp_vec()})
            $display("FAIL midreset_state: got done=%b %s, required done=0 %s",
                     win_done, fmt(dut_vec()), fmt(exp_vec()));
        else n_pass++;
        feed_window(0, 1'b0);
        n_checks++;
        if ({win_done, ones_count, runs_count, win_cnt} !== {1'b1, 11'd512, 11'd512, 16'd1})
            $display("FAIL midreset_window: got done=%b ones=%0d runs=%0d cnt=%0d, required 1 512 512 1",
                     win_done, ones_count, runs_count, win_cnt);
        else n_pass++;
        n_checks++;
        if (dut_vec() !== exp_vec())
            $display("FAIL midreset_result: got %s, required %s", fmt(dut_vec()), fmt(exp_vec()));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gapped();
        test_all_zeros();
        test_alternating();
        test_sticky_clear();
        test_random();
        test_reset_mid_window();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
